// File: rtl/keypad_scanner.sv
// Row driver and column sampler for a 4x4 matrix keypad, feeding keypad_debouncer.
// Optional build macro MULTIKEY_REJECT_EN: treat rows with more than one active column as "no key".
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 3000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] col_n_i,
  output logic [3:0] row_n_o,
  output logic       key_pressed_o,
  output logic [3:0] row_idx_o,
  output logic [3:0] col_idx_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {SCAN, HOLD} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] settleCnt_q;
  logic [3:0]       colMeta_q;
  logic [3:0]       colSync_q;
  logic [3:0]       rowDrive_q;
  logic             keyPressed_q;
  logic [3:0]       rowIdx_q;
  logic [3:0]       colIdx_q;

  logic [3:0]       lowestCol_d;
  logic [3:0]       rowNext_d;
  logic             multiKey_d;
  logic             keyFound_d;
  logic             keyLost_d;

  // Columns are asynchronous to clk; two flops, stored active-high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      colMeta_q <= 4'b0000;
      colSync_q <= 4'b0000;
    end else begin
      colMeta_q <= ~col_n_i;
      colSync_q <= colMeta_q;
    end
  end

  always_comb begin
    lowestCol_d = 4'b0000;
    if (colSync_q[0])      lowestCol_d = 4'b0001;
    else if (colSync_q[1]) lowestCol_d = 4'b0010;
    else if (colSync_q[2]) lowestCol_d = 4'b0100;
    else if (colSync_q[3]) lowestCol_d = 4'b1000;

    rowNext_d = {rowDrive_q[2:0], rowDrive_q[3]};

`ifdef MULTIKEY_REJECT_EN
    multiKey_d = ($countones(colSync_q) > 1);
`else
    multiKey_d = 1'b0;
`endif

    keyFound_d = (colSync_q != 4'b0000) && !multiKey_d;
    keyLost_d  = ((colSync_q & colIdx_q) == 4'b0000) || multiKey_d;
  end

  // Row drive is active-low, so the one-hot row index is simply its inverse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SCAN;
      settleCnt_q  <= '0;
      rowDrive_q   <= 4'b1110;
      keyPressed_q <= 1'b0;
      rowIdx_q     <= 4'b0000;
      colIdx_q     <= 4'b0000;
    end else begin
      case (state_q)
        SCAN: begin
          if (settleCnt_q == CNT_LAST) begin
            settleCnt_q <= '0;
            if (keyFound_d) begin
              state_q      <= HOLD;
              keyPressed_q <= 1'b1;
              rowIdx_q     <= ~rowDrive_q;
              colIdx_q     <= lowestCol_d;
            end else begin
              rowDrive_q <= rowNext_d;
            end
          end else begin
            settleCnt_q <= settleCnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          settleCnt_q <= '0;
          if (keyLost_d) begin
            state_q      <= SCAN;
            rowDrive_q   <= rowNext_d;
            keyPressed_q <= 1'b0;
            rowIdx_q     <= 4'b0000;
            colIdx_q     <= 4'b0000;
          end
        end
        default: begin
          state_q     <= SCAN;
          settleCnt_q <= '0;
        end
      endcase
    end
  end

  assign row_n_o       = rowDrive_q;
  assign key_pressed_o = keyPressed_q;
  assign row_idx_o     = rowIdx_q;
  assign col_idx_o     = colIdx_q;

endmodule
